// File: rtl/mul_accum_stage.sv
// ============================================================================
// mul_accum_stage: accumulates a burst of LEN products from the 3-cycle multiplier
// and returns the sum over valid/ready.
// Optional: `define MUL_ACC_SAT_EN for a saturating accumulator with sticky acc_ovf.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_accum_stage #(
  parameter int PROD_W  = 8,
  parameter int ACC_W   = 16,
  parameter int LEN_W   = 4,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              op_valid,
  input  logic [PROD_W-1:0] mul_out,
  output logic              busy,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
`ifdef MUL_ACC_SAT_EN
  output logic              acc_ovf,
`endif
  input  logic              acc_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued;
  logic [LEN_W-1:0]   received;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_add;
  logic [MUL_LAT-1:0] vpipe;
  logic               accept;
  logic               hit;
  logic               last_hit;

  assign accept   = (state == S_RUN) && (issued < len_q);
  assign hit      = (state == S_RUN) && vpipe[MUL_LAT-1];
  // Finishing on the last hit itself lets acc_valid rise the cycle after the final add.
  assign last_hit = hit && ((received + LEN_W'(1)) == len_q);

  assign busy      = (state != S_IDLE);
  assign acc_valid = (state == S_DONE);
  assign acc_out   = acc;

`ifdef MUL_ACC_SAT_EN
  logic [ACC_W:0] sum_ext;
  assign sum_ext = {1'b0, acc} + (ACC_W+1)'(mul_out);
  assign acc_add = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_add = acc + ACC_W'(mul_out);
`endif

  // Valid pipe mirrors the multiplier latency so its tail lines up with mul_out.
  generate
    if (MUL_LAT == 1) begin : g_pipe_single
      always_ff @(posedge clk) begin
        if (!rst_n) vpipe <= '0;
        else        vpipe <= op_valid & accept;
      end
    end else begin : g_pipe_multi
      always_ff @(posedge clk) begin
        if (!rst_n) vpipe <= '0;
        else        vpipe <= {vpipe[MUL_LAT-2:0], op_valid & accept};
      end
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (len == '0) ? S_DONE : S_RUN;
      S_RUN:  if (last_hit) state_nxt = S_DONE;
      S_DONE: if (acc_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      len_q    <= '0;
      issued   <= '0;
      received <= '0;
      acc      <= '0;
`ifdef MUL_ACC_SAT_EN
      acc_ovf  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q    <= len;
            issued   <= '0;
            received <= '0;
            acc      <= '0;
`ifdef MUL_ACC_SAT_EN
            acc_ovf  <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (op_valid && accept) issued <= issued + LEN_W'(1);
          if (hit) begin
            acc      <= acc_add;
            received <= received + LEN_W'(1);
`ifdef MUL_ACC_SAT_EN
            if (sum_ext[ACC_W]) acc_ovf <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
